// File: rtl/bsg_parallel_in_serial_out_reset_en_if.sv
// rtl/bsg_parallel_in_serial_out_reset_en_if.sv - wide-in / narrow-out handshake bundle
interface bsg_parallel_in_serial_out_reset_en_if #(
   parameter int width_p = 16,
   parameter int els_p   = 4
);
   logic                       valid_i;
   logic [els_p*width_p-1:0]   data_i;
   logic                       ready_and_o;
   logic                       valid_o;
   logic [width_p-1:0]         data_o;
   logic                       yumi_i;

   // master: producer of wide vectors and consumer of narrow words
   modport master (
      output valid_i, data_i, yumi_i,
      input  ready_and_o, valid_o, data_o
   );

   modport slave (
      input  valid_i, data_i, yumi_i,
      output ready_and_o, valid_o, data_o
   );
endinterface

// File: rtl/bsg_parallel_in_serial_out_reset_en.sv
// rtl/bsg_parallel_in_serial_out_reset_en.sv - parallel capture, serial unload, LSB slice first
module bsg_parallel_in_serial_out_reset_en #(
   parameter int width_p = 16,
   parameter int els_p   = 4
) (
   input logic                               clk_i,
   input logic                               reset_i,
   bsg_parallel_in_serial_out_reset_en_if.slave io
);
   localparam int cnt_w = (els_p > 1) ? $clog2(els_p) : 1;
   localparam logic [cnt_w-1:0] last_cnt = cnt_w'(els_p - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]               state_r;
   logic [cnt_w-1:0]         count_r;
   logic [els_p*width_p-1:0] data_r;
   logic                     busy;
   logic                     last;
   logic                     accept;
   logic [width_p-1:0]       word;

   assign busy = (state_r == BUSY);
   assign last = (count_r == last_cnt);

   // Outputs are forced quiet while reset is held so nothing leaks in the reset cycle
   assign io.valid_o     = ~reset_i & busy;
   assign io.ready_and_o = ~reset_i & (~busy | (last & io.yumi_i));
   assign accept         = io.valid_i & io.ready_and_o;

   if (els_p == 1) begin : g_single
      assign word = data_r;
   end else begin : g_multi
      logic [width_p-1:0] slices [els_p];
      for (genvar k = 0; k < els_p; k++) begin : g_slice
         assign slices[k] = data_r[k*width_p +: width_p];
      end
      assign word = slices[count_r];
   end

   assign io.data_o = reset_i ? '0 : word;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= IDLE;
         count_r <= '0;
         data_r  <= '0;
      end else if (accept) begin
         state_r <= BUSY;
         count_r <= '0;
         data_r  <= io.data_i;
      end else if (busy && io.yumi_i) begin
         if (last) begin
            state_r <= IDLE;
         end else begin
            count_r <= count_r + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         assert (!(io.yumi_i && !io.valid_o))
            else $error("yumi_i asserted while valid_o is low");
      end
   end
endmodule

// File: tb/tb_bsg_parallel_in_serial_out_reset_en.sv
// tb/tb_bsg_parallel_in_serial_out_reset_en.sv - directed table, els_p=1 sequence, randomized model check
module tb_bsg_parallel_in_serial_out_reset_en;
   logic clk = 1'b0;
   logic rst4;
   logic rst1;
   int   tests = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   bsg_parallel_in_serial_out_reset_en_if #(.width_p(16), .els_p(4)) bus4 ();
   bsg_parallel_in_serial_out_reset_en_if #(.width_p(8),  .els_p(1)) bus1 ();

   bsg_parallel_in_serial_out_reset_en #(.width_p(16), .els_p(4)) dut4 (
      .clk_i(clk), .reset_i(rst4), .io(bus4)
   );
   bsg_parallel_in_serial_out_reset_en #(.width_p(8), .els_p(1)) dut1 (
      .clk_i(clk), .reset_i(rst1), .io(bus1)
   );

   typedef struct {
      logic        rst;
      logic        v;
      logic [63:0] d;
      logic        y;
      logic        ev;
      logic        er;
      logic [15:0] ed;
      logic        cd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic v, logic [63:0] d, logic y,
                               logic ev, logic er, logic [15:0] ed, logic cd);
      vec_t t;
      t.rst = rst; t.v = v; t.d = d; t.y = y;
      t.ev = ev; t.er = er; t.ed = ed; t.cd = cd;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   localparam logic [63:0] VA = 64'h4444_3333_2222_1111;
   localparam logic [63:0] VB = 64'hDDDD_CCCC_BBBB_AAAA;

   logic [15:0] q[$];
   logic        r, v, y, ev, er;
   logic [63:0] d;

   initial begin
      rst4 = 1'b1; rst1 = 1'b1;
      bus4.valid_i = 1'b0; bus4.data_i = '0; bus4.yumi_i = 1'b0;
      bus1.valid_i = 1'b0; bus1.data_i = '0; bus1.yumi_i = 1'b0;

      //            rst v  data y   ev er data    cd
      vecs.push_back(mk(1, 0, 0,  0,  0, 0, 16'h0,    1));
      vecs.push_back(mk(1, 0, 0,  0,  0, 0, 16'h0,    1));
      vecs.push_back(mk(0, 1, VA, 0,  0, 1, 16'h0,    1));
      vecs.push_back(mk(0, 0, 0,  1,  1, 0, 16'h1111, 1));
      vecs.push_back(mk(0, 0, 0,  1,  1, 0, 16'h2222, 1));
      vecs.push_back(mk(0, 0, 0,  1,  1, 0, 16'h3333, 1));
      vecs.push_back(mk(0, 1, VB, 1,  1, 1, 16'h4444, 1));
      vecs.push_back(mk(0, 0, 0,  1,  1, 0, 16'hAAAA, 1));
      vecs.push_back(mk(0, 0, 0,  1,  1, 0, 16'hBBBB, 1));
      vecs.push_back(mk(0, 0, 0,  1,  1, 0, 16'hCCCC, 1));
      vecs.push_back(mk(0, 0, 0,  1,  1, 1, 16'hDDDD, 1));
      vecs.push_back(mk(0, 1, VA, 0,  0, 1, 16'h0,    0));
      vecs.push_back(mk(0, 0, 0,  0,  1, 0, 16'h1111, 1));
      vecs.push_back(mk(0, 1, VB, 0,  1, 0, 16'h1111, 1));
      vecs.push_back(mk(0, 0, 0,  0,  1, 0, 16'h1111, 1));
      vecs.push_back(mk(0, 1, VB, 0,  1, 0, 16'h1111, 1));
      vecs.push_back(mk(0, 1, VB, 0,  1, 0, 16'h1111, 1));
      vecs.push_back(mk(0, 1, VB, 1,  1, 0, 16'h1111, 1));
      vecs.push_back(mk(0, 0, 0,  1,  1, 0, 16'h2222, 1));
      vecs.push_back(mk(1, 1, VB, 0,  0, 0, 16'h0,    1));
      vecs.push_back(mk(0, 0, 0,  0,  0, 1, 16'h0,    1));
      vecs.push_back(mk(0, 1, VB, 0,  0, 1, 16'h0,    1));
      vecs.push_back(mk(0, 0, 0,  1,  1, 0, 16'hAAAA, 1));
      vecs.push_back(mk(0, 0, 0,  1,  1, 0, 16'hBBBB, 1));
      vecs.push_back(mk(0, 0, 0,  1,  1, 0, 16'hCCCC, 1));
      vecs.push_back(mk(0, 0, 0,  1,  1, 1, 16'hDDDD, 1));
      vecs.push_back(mk(0, 0, 0,  0,  0, 1, 16'h0,    0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst4 = vecs[i].rst;
         bus4.valid_i = vecs[i].v;
         bus4.data_i  = vecs[i].d;
         bus4.yumi_i  = vecs[i].y;
         #1;
         chk($sformatf("row%0d valid_o", i), {63'd0, bus4.valid_o}, {63'd0, vecs[i].ev});
         chk($sformatf("row%0d ready_and_o", i), {63'd0, bus4.ready_and_o}, {63'd0, vecs[i].er});
         if (vecs[i].cd)
            chk($sformatf("row%0d data_o", i), {48'd0, bus4.data_o}, {48'd0, vecs[i].ed});
      end

      // els_p=1: one-element fifo, back-to-back vectors
      @(negedge clk); rst1 = 1'b1;
      @(negedge clk); rst1 = 1'b1;
      @(negedge clk);
      rst1 = 1'b0; bus1.valid_i = 1'b1; bus1.data_i = 8'h5A; bus1.yumi_i = 1'b0;
      #1;
      chk("e1 idle ready", {63'd0, bus1.ready_and_o}, 64'd1);
      chk("e1 idle valid", {63'd0, bus1.valid_o}, 64'd0);
      @(negedge clk);
      bus1.valid_i = 1'b1; bus1.data_i = 8'hA5; bus1.yumi_i = 1'b1;
      #1;
      chk("e1 first valid", {63'd0, bus1.valid_o}, 64'd1);
      chk("e1 first data", {56'd0, bus1.data_o}, 64'h5A);
      chk("e1 first ready", {63'd0, bus1.ready_and_o}, 64'd1);
      @(negedge clk);
      bus1.valid_i = 1'b0; bus1.data_i = 8'h00; bus1.yumi_i = 1'b1;
      #1;
      chk("e1 second valid", {63'd0, bus1.valid_o}, 64'd1);
      chk("e1 second data", {56'd0, bus1.data_o}, 64'hA5);
      chk("e1 second ready", {63'd0, bus1.ready_and_o}, 64'd1);
      @(negedge clk);
      bus1.yumi_i = 1'b0;
      #1;
      chk("e1 drained valid", {63'd0, bus1.valid_o}, 64'd0);

      // randomized traffic against a word-queue model
      q.delete();
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         r = (i < 2) || ($urandom_range(0, 59) == 0);
         v = $urandom_range(0, 1) == 1;
         d = {$urandom, $urandom};
         if (r) begin
            ev = 1'b0; er = 1'b0; y = 1'b0;
         end else begin
            ev = (q.size() != 0);
            y  = ev && ($urandom_range(0, 3) != 0);
            er = (q.size() == 0) || (q.size() == 1 && y);
         end
         rst4 = r; bus4.valid_i = v; bus4.data_i = d; bus4.yumi_i = y;
         #1;
         chk($sformatf("rnd%0d valid_o", i), {63'd0, bus4.valid_o}, {63'd0, ev});
         chk($sformatf("rnd%0d ready_and_o", i), {63'd0, bus4.ready_and_o}, {63'd0, er});
         if (r)
            chk($sformatf("rnd%0d reset data_o", i), {48'd0, bus4.data_o}, 64'd0);
         else if (ev)
            chk($sformatf("rnd%0d data_o", i), {48'd0, bus4.data_o}, {48'd0, q[0]});
         if (r) begin
            q.delete();
         end else begin
            if (y) void'(q.pop_front());
            if (v && er)
               for (int k = 0; k < 4; k++) q.push_back(d[k*16 +: 16]);
         end
      end

      @(negedge clk);
      bus4.valid_i = 1'b0; bus4.yumi_i = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
